// File: rtl/sha256_unround_if.sv
// Request/result bundle for the SHA-256 inverse-round engine.
interface sha256_unround_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [255:0] h_i;
  logic [511:0] m_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [255:0] h_o;
  logic [511:0] m_o;
  logic         busy_o;

  modport master (
    output in_valid_i, h_i, m_i, out_ready_i,
    input  in_ready_o, out_valid_o, h_o, m_o, busy_o
  );

  modport slave (
    input  in_valid_i, h_i, m_i, out_ready_i,
    output in_ready_o, out_valid_o, h_o, m_o, busy_o
  );
endinterface

// File: rtl/sha256_unround_iter.sv
// Iterative inverse of the 64 SHA-256 compression rounds. Takes the post-round-63
// working state and final message window and walks back to the initial state and block.
module sha256_unround_iter #(
  parameter int unsigned UNROLL = 1
) (
  input logic             clk,
  input logic             rst_n,
  sha256_unround_if.slave bus
);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One inverse round t: returns {window, state}. The word consumed by round t is always
  // the top word of the incoming window; below round 16 the window just rotates.
  function automatic logic [767:0] inv_round(input logic [255:0] s, input logic [511:0] w,
                                              input logic [5:0] t);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, wt, wn;
    a  = s[63:32];
    b  = s[95:64];
    c  = s[127:96];
    e  = s[191:160];
    f  = s[223:192];
    g  = s[255:224];
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    t1 = s[31:0] - t2;
    d  = s[159:128] - t1;
    wt = w[511:480];
    if (t >= 6'd16) begin
      wn = wt - ssig1(w[447:416]) - w[287:256] - ssig0(w[31:0]);
    end else begin
      wn = wt;
    end
    h = t1 - bsig1(e) - ((e & f) ^ (~e & g)) - K[t] - wt;
    return {w[479:0], wn, h, g, f, e, d, c, b, a};
  endfunction

  state_e       state_q;
  logic [5:0]   t_q;
  logic [255:0] st_q, st_n, h_q;
  logic [511:0] win_q, win_n, m_q;
  logic         out_valid_q, busy_q;
  logic         last_step;

  assign last_step       = (t_q == 6'(UNROLL - 1));
  assign bus.in_ready_o  = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready_i);
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.h_o         = h_q;
  assign bus.m_o         = m_q;

  // Chain UNROLL inverse rounds t, t-1, ... from the working registers.
  always_comb begin
    st_n  = st_q;
    win_n = win_q;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      {win_n, st_n} = inv_round(st_n, win_n, t_q - 6'(u));
    end
  end

  // Control FSM with registered result and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      t_q         <= 6'd63;
      st_q        <= '0;
      win_q       <= '0;
      h_q         <= '0;
      m_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid_i) begin
            st_q    <= bus.h_i;
            win_q   <= bus.m_i;
            t_q     <= 6'd63;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          st_q  <= st_n;
          win_q <= win_n;
          // Wraps to 63 on the step that finishes round 0.
          t_q   <= t_q - 6'(UNROLL);
          if (last_step) begin
            h_q         <= st_n;
            m_q         <= win_n;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid_i) begin
              st_q    <= bus.h_i;
              win_q   <= bus.m_i;
              t_q     <= 6'd63;
              busy_q  <= 1'b1;
              state_q <= StRun;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_unround_iter.sv
// Bench for sha256_unround_iter: three instances (UNROLL 1, 4, 16) driven from a forward
// SHA-256 model, plus the FIPS "abc" vector, back-to-back and mid-run reset cases.
module tb_sha256_unround_iter;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] DIGEST = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                     32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iv   [3];
  logic         ordy [3];
  logic [255:0] hin  [3];
  logic [511:0] min  [3];
  logic         irdy [3];
  logic         ov   [3];
  logic         busy [3];
  logic [255:0] hout [3];
  logic [511:0] mout [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned U = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    sha256_unround_if bus ();
    assign bus.in_valid_i  = iv[g];
    assign bus.h_i         = hin[g];
    assign bus.m_i         = min[g];
    assign bus.out_ready_i = ordy[g];
    assign irdy[g]         = bus.in_ready_o;
    assign ov[g]           = bus.out_valid_o;
    assign busy[g]         = bus.busy_o;
    assign hout[g]         = bus.h_o;
    assign mout[g]         = bus.m_o;
    sha256_unround_iter #(.UNROLL(U)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  function automatic int unroll_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 4 : 16);
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Forward SHA-256 compression without the final chaining add.
  function automatic void sha_fwd(input logic [255:0] h0, input logic [511:0] blk,
                                  output logic [255:0] hf, output logic [511:0] mf);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    {h, g, f, e, d, c, b, a} = h0;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hf = {h, g, f, e, d, c, b, a};
    for (int i = 0; i < 16; i++) mf[32*i +: 32] = w[48+i];
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Issue one request on instance idx and collect its result; starts and ends on a negedge.
  task automatic do_request(input int idx, input logic [255:0] h, input logic [511:0] m,
                            input bit stall, input string tag,
                            output logic [255:0] ho, output logic [511:0] mo, output int lat);
    int  n;
    int  ns;
    bit  run_ok;
    bit  stable_ok;
    iv[idx] = 1'b1;
    hin[idx] = h;
    min[idx] = m;
    n = 0;
    while (!irdy[idx] && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check({tag, "_accept"}, irdy[idx], 1'b1);
    @(posedge clk); @(negedge clk);
    iv[idx] = 1'b0;
    hin[idx] = rand512()[255:0];
    min[idx] = rand512();
    lat = 0;
    run_ok = 1'b1;
    while (!ov[idx] && lat < 200) begin
      if (irdy[idx] || !busy[idx]) run_ok = 1'b0;
      @(posedge clk); @(negedge clk); lat++;
    end
    check({tag, "_done"}, ov[idx], 1'b1);
    check({tag, "_run_flags"}, run_ok, 1'b1);
    ho = hout[idx];
    mo = mout[idx];
    if (stall) begin
      stable_ok = 1'b1;
      ns = $urandom_range(1, 4);
      ordy[idx] = 1'b0;
      for (int s = 0; s < ns; s++) begin
        @(posedge clk); @(negedge clk);
        if (hout[idx] !== ho || mout[idx] !== mo || !ov[idx] || irdy[idx]) stable_ok = 1'b0;
      end
      check({tag, "_stall_stable"}, stable_ok, 1'b1);
    end
    ordy[idx] = 1'b1;
    @(posedge clk); @(negedge clk);
    ordy[idx] = 1'b0;
    check({tag, "_valid_drop"}, ov[idx], 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] abc_h, ho, hA, hB, hC, hm;
    logic [511:0] abc_blk, abc_m, mo, mA, mB, mC, mm, blk;
    int           lat;
    bit           run_ok;

    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; hin[i] = '0; min[i] = '0;
    end
    abc_blk = '0;
    abc_blk[31:0] = 32'h61626380;
    abc_blk[511:480] = 32'h00000018;
    for (int i = 0; i < 8; i++) abc_h[32*i +: 32] = DIGEST[32*i +: 32] - IV[32*i +: 32];

    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_in_ready%0d", i), irdy[i], 1'b1);
      check($sformatf("rst_out_valid%0d", i), ov[i], 1'b0);
      check($sformatf("rst_busy%0d", i), busy[i], 1'b0);
      check($sformatf("rst_h%0d", i), hout[i], '0);
      check($sformatf("rst_m%0d", i), mout[i], '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bench model must reproduce the published "abc" digest before it is trusted.
    sha_fwd(IV, abc_blk, hm, abc_m);
    check("model_abc", hm, abc_h);
    check("abc_a_word", abc_h[31:0], 32'h506e3058);

    for (int i = 0; i < 3; i++) begin
      do_request(i, abc_h, abc_m, 1'b0, $sformatf("abc%0d", i), ho, mo, lat);
      check($sformatf("abc_h%0d", i), ho, IV);
      check($sformatf("abc_m%0d", i), mo, abc_blk);
      check($sformatf("abc_lat%0d", i), lat, 64 / unroll_of(i));
    end

    for (int n = 0; n < 1000; n++) begin
      hC = rand512()[255:0];
      blk = rand512();
      sha_fwd(hC, blk, hm, mm);
      do_request(n % 3, hm, mm, ($urandom_range(0, 1) == 1), "rnd", ho, mo, lat);
      check("rnd_h", ho, hC);
      check("rnd_m", mo, blk);
      check("rnd_lat", lat, 64 / unroll_of(n % 3));
    end

    // Back-to-back on the UNROLL=16 instance.
    hA = rand512()[255:0]; mA = rand512();
    hB = rand512()[255:0]; mB = rand512();
    sha_fwd(hA, mA, hm, mm);
    ordy[2] = 1'b1;
    iv[2] = 1'b1; hin[2] = hm; min[2] = mm;
    check("b2b_idle_ready", irdy[2], 1'b1);
    @(posedge clk); @(negedge clk);
    sha_fwd(hB, mB, hin[2], min[2]);
    lat = 0; run_ok = 1'b1;
    while (!ov[2] && lat < 100) begin
      if (irdy[2]) run_ok = 1'b0;
      @(posedge clk); @(negedge clk); lat++;
    end
    check("b2b_lat_a", lat, 4);
    check("b2b_run_ready_a", run_ok, 1'b1);
    check("b2b_ready_done", irdy[2], 1'b1);
    check("b2b_h_a", hout[2], hA);
    check("b2b_m_a", mout[2], mA);
    @(posedge clk); @(negedge clk);
    iv[2] = 1'b0;
    check("b2b_no_idle_valid", ov[2], 1'b0);
    check("b2b_no_idle_busy", busy[2], 1'b1);
    lat = 0; run_ok = 1'b1;
    while (!ov[2] && lat < 100) begin
      if (irdy[2]) run_ok = 1'b0;
      @(posedge clk); @(negedge clk); lat++;
    end
    check("b2b_lat_b", lat, 4);
    check("b2b_run_ready_b", run_ok, 1'b1);
    check("b2b_h_b", hout[2], hB);
    check("b2b_m_b", mout[2], mB);
    @(posedge clk); @(negedge clk);
    ordy[2] = 1'b0;
    check("b2b_drop", ov[2], 1'b0);

    // Reset 30 cycles into a run on the UNROLL=1 instance.
    hA = rand512()[255:0]; mA = rand512();
    sha_fwd(hA, mA, hm, mm);
    iv[0] = 1'b1; hin[0] = hm; min[0] = mm;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    repeat (30) begin @(posedge clk); @(negedge clk); end
    check("mid_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_run_valid", ov[0], 1'b0);
    check("rst_run_h", hout[0], '0);
    check("rst_run_ready", irdy[0], 1'b1);
    check("rst_run_busy", busy[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); @(negedge clk); end
    check("rst_no_stale_valid", ov[0], 1'b0);
    hC = rand512()[255:0]; mC = rand512();
    sha_fwd(hC, mC, hm, mm);
    do_request(0, hm, mm, 1'b0, "post_rst", ho, mo, lat);
    check("post_rst_h", ho, hC);
    check("post_rst_m", mo, mC);
    check("post_rst_lat", lat, 64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
